// File: rtl/ap_ctrl_txn_profiler.sv
// Per-transaction profiler for one ap_ctrl_hs block and its pipelined loop.
// Records {MOD_ID, complete, latency, iters, stalls[, start timestamp]} are queued
// in a small FIFO and streamed out over valid/ready.
// Optional: AP_CTRL_TXN_PROFILER_TIMESTAMP_EN appends the start-cycle timestamp.
module ap_ctrl_txn_profiler #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned MOD_ID     = 0,
    parameter int unsigned FIFO_DEPTH = 4,
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
    localparam int unsigned REC_W     = ID_W + 1 + 4 * CNT_W,
`else
    localparam int unsigned REC_W     = ID_W + 1 + 3 * CNT_W,
`endif
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             iter_start_enable,
    input  logic             iter_start_block,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_data,
    output logic             rec_overflow,
    output logic             drained,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] lat_q, lat_d, iters_q, iters_d, stalls_q, stalls_d;
    logic [CNT_W-1:0] lat_inc, iters_inc, stalls_inc;
    logic             push_c, complete_c, reload_c;
    logic [REC_W-1:0] rec_c;

    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [REC_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic [REC_W-1:0] data_q, data_d;
    logic             overflow_q, overflow_d;
    logic             drained_q, drained_d;
    logic             pop_c, do_push_c;

`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_q, ts_d, start_ts_q, start_ts_d;
`endif

    // ap_ready is observed only; handshake completion is keyed off ap_done.
    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            iters_q    <= '0;
            stalls_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
            ts_q       <= '0;
            start_ts_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            iters_q    <= iters_d;
            stalls_q   <= stalls_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            drained_q  <= drained_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= mem_d[i];
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
            ts_q       <= ts_d;
            start_ts_q <= start_ts_d;
`endif
        end
    end

    // Next state: finish outranks start/done; DRAIN waits for the FIFO to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (finish)        state_d = DRAIN;
                else if (ap_start) state_d = BUSY;
            end
            BUSY: begin
                if (finish)                    state_d = DRAIN;
                else if (ap_done && !ap_start) state_d = IDLE;
            end
            DRAIN: begin
                if (count_d == '0) state_d = DONE;
            end
            default: state_d = state_q;
        endcase
    end

    // Counters and record push; the reported values include the current cycle.
    always_comb begin
        lat_inc    = sat_inc(lat_q);
        iters_inc  = (iter_start_enable && !iter_start_block) ? sat_inc(iters_q) : iters_q;
        stalls_inc = iter_start_block ? sat_inc(stalls_q) : stalls_q;
        lat_d      = lat_q;
        iters_d    = iters_q;
        stalls_d   = stalls_q;
        push_c     = 1'b0;
        complete_c = 1'b0;
        reload_c   = 1'b0;
        drained_d  = (state_d == DONE);
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
        ts_d       = ts_q + CNT_W'(1);
        start_ts_d = start_ts_q;
`endif
        case (state_q)
            IDLE: reload_c = !finish && ap_start;
            BUSY: begin
                lat_d      = lat_inc;
                iters_d    = iters_inc;
                stalls_d   = stalls_inc;
                push_c     = finish || ap_done;
                complete_c = ap_done;
                reload_c   = !finish && ap_done && ap_start;
            end
            default: ;
        endcase
        if (reload_c) begin
            lat_d    = CNT_W'(1);
            iters_d  = '0;
            stalls_d = '0;
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
            start_ts_d = ts_q;
`endif
        end
    end

`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
    assign rec_c = {ID_W'(MOD_ID), complete_c, lat_inc, iters_inc, stalls_inc, start_ts_q};
`else
    assign rec_c = {ID_W'(MOD_ID), complete_c, lat_inc, iters_inc, stalls_inc};
`endif

    // Record FIFO; the head entry is re-registered so rec_data comes straight from a flop.
    always_comb begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_d[i] = mem_q[i];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        pop_c      = valid_q && rec_ready;
        do_push_c  = push_c && ((count_q != LVL_W'(FIFO_DEPTH)) || pop_c);
        if (push_c && !do_push_c) overflow_d = 1'b1;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = rec_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + LVL_W'(do_push_c) - LVL_W'(pop_c);
        valid_d = (count_d != '0);
        data_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    assign rec_valid    = valid_q;
    assign rec_data     = data_q;
    assign rec_overflow = overflow_q;
    assign drained      = drained_q;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Scoreboard bench for ap_ctrl_txn_profiler: directed transactions push expected
// records; a negedge monitor compares every accepted record in order.
module tb_ap_ctrl_txn_profiler;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned MOD_ID     = 5;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
    localparam int unsigned REC_W      = ID_W + 1 + 4 * CNT_W;
`else
    localparam int unsigned REC_W      = ID_W + 1 + 3 * CNT_W;
`endif
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             ap_start, ap_ready, ap_done;
    logic             iter_start_enable, iter_start_block, finish;
    logic             rec_valid, rec_ready, rec_overflow, drained;
    logic [REC_W-1:0] rec_data;
    logic [LVL_W-1:0] fifo_level;

    int checks   = 0;
    int failures = 0;
    logic [REC_W-1:0] exp_q [$];

    always #5 ap_clk = ~ap_clk;

    ap_ctrl_txn_profiler #(
        .CNT_W(CNT_W), .ID_W(ID_W), .MOD_ID(MOD_ID), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .iter_start_enable(iter_start_enable),
        .iter_start_block(iter_start_block), .finish(finish), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_data(rec_data), .rec_overflow(rec_overflow),
        .drained(drained), .fifo_level(fifo_level)
    );

`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
    logic [CNT_W-1:0] tb_cyc;
    logic [CNT_W-1:0] cur_ts;
    always @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) tb_cyc <= '0;
        else           tb_cyc <= tb_cyc + CNT_W'(1);

    function automatic logic [REC_W-1:0] mk(input logic c, input int lat, input int it, input int st);
        return {ID_W'(MOD_ID), c, CNT_W'(lat), CNT_W'(it), CNT_W'(st), cur_ts};
    endfunction
    task automatic mark_ts();
        cur_ts = tb_cyc;
    endtask
`else
    function automatic logic [REC_W-1:0] mk(input logic c, input int lat, input int it, input int st);
        return {ID_W'(MOD_ID), c, CNT_W'(lat), CNT_W'(it), CNT_W'(st)};
    endfunction
    task automatic mark_ts();
    endtask
`endif

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: every accepted record must match the head of the scoreboard.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record got=%0h expected=none", rec_data);
            end else begin
                chk("rec_data", 128'(rec_data), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int en_t  [5] = '{0, 1, 0, 0, 1};
    int blk_t [5] = '{0, 0, 1, 0, 1};

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        iter_start_enable = 1'b0; iter_start_block = 1'b0; finish = 1'b0; rec_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_valid", 128'(rec_valid), 128'(0));
        chk("rst_data", 128'(rec_data), 128'(0));
        chk("rst_overflow", 128'(rec_overflow), 128'(0));
        chk("rst_drained", 128'(drained), 128'(0));
        chk("rst_level", 128'(fifo_level), 128'(0));
        ap_rst_n = 1'b1;

        // Single transaction: 6 cycles, 3 iterations, 1 stall.
        mark_ts();
        exp_q.push_back(mk(1'b1, 6, 3, 1));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        iter_start_enable = 1'b1; repeat (3) tick();
        iter_start_block = 1'b1; tick();
        iter_start_enable = 1'b0; iter_start_block = 1'b0; ap_done = 1'b1;
        chk("t1_valid_c5", 128'(rec_valid), 128'(0));
        tick(); ap_done = 1'b0;
        chk("t1_valid_c6", 128'(rec_valid), 128'(1));
        tick();
        chk("t1_valid_c7", 128'(rec_valid), 128'(0));

        // Done while idle must not produce a record.
        ap_done = 1'b1; tick(); ap_done = 1'b0; tick();

        // Back-to-back: done+start share cycle 5, second done at cycle 8.
        mark_ts();
        exp_q.push_back(mk(1'b1, 6, 0, 0));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        repeat (4) tick();
        ap_done = 1'b1; ap_start = 1'b1;
        mark_ts();
        exp_q.push_back(mk(1'b1, 4, 0, 0));
        tick(); ap_done = 1'b0; ap_start = 1'b0;
        repeat (2) tick();
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        repeat (3) tick();

        // Saturation of all three counters.
        mark_ts();
        exp_q.push_back(mk(1'b1, 255, 255, 255));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        iter_start_enable = 1'b1; repeat (300) tick();
        iter_start_block = 1'b1; repeat (300) tick();
        iter_start_enable = 1'b0; iter_start_block = 1'b0;
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        repeat (3) tick();

        // Backpressure: five 2-cycle transactions into a 4-deep FIFO.
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mark_ts();
            if (i < 4)
                exp_q.push_back(mk(1'b1, 2, (en_t[i] != 0 && blk_t[i] == 0) ? 1 : 0, blk_t[i]));
            ap_start = 1'b1; tick(); ap_start = 1'b0;
            ap_done = 1'b1;
            iter_start_enable = (en_t[i] != 0);
            iter_start_block  = (blk_t[i] != 0);
            tick();
            ap_done = 1'b0; iter_start_enable = 1'b0; iter_start_block = 1'b0;
        end
        chk("bp_level_full", 128'(fifo_level), 128'(4));
        chk("bp_overflow", 128'(rec_overflow), 128'(1));
        chk("bp_valid", 128'(rec_valid), 128'(1));
        repeat (2) tick();
        chk("bp_head_stable", 128'(rec_data), 128'(exp_q[0]));
        rec_ready = 1'b1;
        for (int k = 0; k < 20 && fifo_level != '0; k++) tick();
        chk("bp_drained", 128'(fifo_level), 128'(0));
        chk("bp_overflow_sticky", 128'(rec_overflow), 128'(1));

        // Reset during BUSY with two records queued.
        rec_ready = 1'b0;
        repeat (2) begin
            ap_start = 1'b1; tick(); ap_start = 1'b0;
            ap_done = 1'b1; tick(); ap_done = 1'b0;
        end
        ap_start = 1'b1; tick(); ap_start = 1'b0; tick();
        chk("rst_pre_level", 128'(fifo_level), 128'(2));
        #2 ap_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_valid", 128'(rec_valid), 128'(0));
        chk("rst_mid_level", 128'(fifo_level), 128'(0));
        chk("rst_mid_overflow", 128'(rec_overflow), 128'(0));
        tick();
        chk("rst_next_valid", 128'(rec_valid), 128'(0));
        chk("rst_next_level", 128'(fifo_level), 128'(0));
        ap_rst_n = 1'b1;
        rec_ready = 1'b1;
`ifdef AP_CTRL_TXN_PROFILER_TIMESTAMP_EN
        // Start at cycle 10 after release carries timestamp 10.
        repeat (10) tick();
        cur_ts = CNT_W'(10);
        exp_q.push_back(mk(1'b1, 2, 0, 0));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        repeat (3) tick();
`else
        repeat (8) tick();
`endif
        chk("rst_no_record", 128'(rec_valid), 128'(0));

        // Finish in BUSY at cycle 3: partial record, then DRAIN -> DONE.
        mark_ts();
        exp_q.push_back(mk(1'b0, 4, 0, 0));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        repeat (2) tick();
        finish = 1'b1; tick(); finish = 1'b0;
        chk("fin_valid_c4", 128'(rec_valid), 128'(1));
        chk("fin_drained_c4", 128'(drained), 128'(0));
        tick();
        chk("fin_drained_c5", 128'(drained), 128'(1));
        chk("fin_valid_c5", 128'(rec_valid), 128'(0));
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        repeat (3) tick();
        chk("done_hold_drained", 128'(drained), 128'(1));
        chk("done_hold_level", 128'(fifo_level), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
